mux2_arbiter: RTL
=================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the data width of each channel and of the output.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates occur on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 Port in0_data SHALL be an input, DW bits wide: channel 0 payload.
REQ-005 Port in0_valid SHALL be an input, 1 bit wide: channel 0 payload valid.
REQ-006 Port in0_ready SHALL be an output, 1 bit wide: channel 0 beat accepted this cycle.
REQ-007 Port in1_data SHALL be an input, DW bits wide: channel 1 payload.
REQ-008 Port in1_valid SHALL be an input, 1 bit wide: channel 1 payload valid.
REQ-009 Port in1_ready SHALL be an output, 1 bit wide: channel 1 beat accepted this cycle.
REQ-010 Port sel SHALL be an output, 1 bit wide: current grant, driven to the S input of the downstream 2:1 mux; 0 selects channel 0, 1 selects channel 1.
REQ-011 Port out_data SHALL be an output, DW bits wide: registered payload of the granted beat.
REQ-012 Port out_valid SHALL be an output, 1 bit wide: out_data holds a beat.
REQ-013 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts out_data.
REQ-014 Port out_src SHALL be an output, 1 bit wide: channel index of the beat in out_data.

Function
REQ-015 Transfers SHALL follow valid/ready rules: a beat moves on any edge where valid and ready are both high; valid never depends combinationally on ready.
REQ-016 The output stage SHALL be one register entry; it is free when out_valid=0 or out_ready=1 (drain and refill in the same cycle, full throughput).
REQ-017 The grant SHALL be computed combinationally each cycle: only one channel valid -> that channel; both valid -> the channel not equal to last_grant; neither valid -> sel holds its previous value.
REQ-018 inN_ready SHALL be 1 only when the output stage is free and sel=N; the non-granted channel's ready SHALL be 0.
REQ-019 On acceptance, out_data<=granted data, out_src<=sel, out_valid<=1, and last_grant<=sel; the latency from input handshake to out_valid is 1 cycle.
REQ-020 When out_valid=1 and out_ready=1 and no beat is accepted, out_valid SHALL go to 0 on that edge.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_src and out_valid SHALL hold, and both in_ready SHALL be 0.
REQ-022 A held inN_valid with no handshake SHALL never be dropped; channel payloads are sampled only on a handshake.
REQ-023 Under continuous contention with out_ready=1, grants SHALL alternate 0,1,0,1,...; no channel waits more than one accepted beat.

Reset
REQ-024 While rst=1 at an edge: out_valid=0, out_data=0, out_src=0, sel register=0, last_grant=1 (channel 0 wins the first contention), lock state cleared.
REQ-025 Reset mid-transfer SHALL discard the buffered beat; in0_ready and in1_ready SHALL be 0 during the reset cycle.

Configuration
REQ-026 Macro MUX2_ARB_LOCK_EN SHALL, when defined, add input ports in0_last and in1_last (1 bit each) and a lock flag: after a granted beat with last=0 is accepted, the grant stays fixed on that channel, ignoring the other channel's valid, until a beat with last=1 from it is accepted, then normal round-robin resumes.
REQ-027 Without MUX2_ARB_LOCK_EN, the last ports and lock flag SHALL not exist, and arbitration is per beat as in REQ-017.

Verification
REQ-028 Reset, then in0_valid=1 and in1_valid=1 with data 0x11/0x22, out_ready=1 -> outputs 0x11(src0), 0x22(src1), 0x11, alternating each cycle.
REQ-029 Only in1_valid=1 with data 0x5A -> sel=1, in1_ready=1, next cycle out_data=0x5A, out_src=1, out_valid=1.
REQ-030 out_ready=0 for 3 cycles while out_valid=1 with 0x33 -> out_data stays 0x33, both in_ready stay 0, and the input beats are delivered in order after release.
REQ-031 rst asserted while out_valid=1 -> next edge out_valid=0, out_data=0; the first contention after reset grants channel 0.
REQ-032 With MUX2_ARB_LOCK_EN: ch0 sends 3 beats with last=0,0,1 while ch1 is valid throughout -> out_src=0,0,0, then 1.
REQ-033 Back-to-back drain/refill, out_ready=1, 100 random beats on both channels -> zero bubbles, every beat delivered exactly once, grant never repeats under contention.

Source files
------------

// File: rtl/mux2_arbiter.sv
// Round-robin 2:1 arbiter feeding a single registered output slot (valid/ready on all sides).
// Optional build macro MUX2_ARB_LOCK_EN adds in0_last/in1_last and holds the grant until a packet ends.
module mux2_arbiter #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_valid,
  output logic          in1_ready,
`ifdef MUX2_ARB_LOCK_EN
  input  logic          in0_last,
  input  logic          in1_last,
`endif
  output logic          sel,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_src
);

  logic          sel_q;
  logic          last_grant;
  logic          rr_sel;
  logic          slot_free;
  logic          accept;
  logic [DW-1:0] grant_data;

  // Per-beat round-robin choice; with no requester the previous grant is held.
  always_comb begin
    rr_sel = sel_q;
    if (in0_valid && in1_valid) begin
      rr_sel = ~last_grant;
    end else if (in0_valid) begin
      rr_sel = 1'b0;
    end else if (in1_valid) begin
      rr_sel = 1'b1;
    end
  end

`ifdef MUX2_ARB_LOCK_EN
  logic lock_q;
  logic grant_last;

  // While a packet is open the grant stays on the channel that opened it.
  always_comb begin
    sel        = lock_q ? last_grant : rr_sel;
    grant_last = sel ? in1_last : in0_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (accept) begin
      lock_q <= ~grant_last;
    end
  end
`else
  always_comb begin
    sel = rr_sel;
  end
`endif

  // The slot can take a beat when empty or when its content drains on this edge.
  always_comb begin
    slot_free  = ~out_valid | out_ready;
    in0_ready  = ~rst & slot_free & ~sel;
    in1_ready  = ~rst & slot_free & sel;
    accept     = sel ? (in1_valid & in1_ready) : (in0_valid & in0_ready);
    grant_data = sel ? in1_data : in0_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 1'b0;
      sel_q      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      sel_q <= sel;
      if (accept) begin
        out_valid  <= 1'b1;
        out_data   <= grant_data;
        out_src    <= sel;
        last_grant <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
